// File: rtl/csr_access_unit.sv
// CSR-file initiator: read-modify-write sequencing for Zicsr instructions and
// the machine-trap entry sequence (mepc, mcause, redirect to mtvec).
module csr_access_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 12,
  parameter logic [ADDR_W-1:0] ADDR_MEPC   = 12'h341,
  parameter logic [ADDR_W-1:0] ADDR_MCAUSE = 12'h342
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_csr,
  input  logic [4:0]        req_rs1_idx,
  input  logic [XLEN-1:0]   req_rs1_val,
  input  logic [4:0]        req_rd_idx,
  output logic              resp_valid,
  output logic              resp_rd_wen,
  output logic [4:0]        resp_rd_idx,
  output logic [XLEN-1:0]   resp_rd_data,
  output logic              resp_illegal,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_cause,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              csr_w_enable,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic [XLEN-1:0]   mtvec
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_RESP, S_TRAP_EPC, S_TRAP_CAUSE, S_TRAP_REDIR
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] csr_q;
  logic [4:0]        idx_q;
  logic [XLEN-1:0]   val_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   old_q, new_q, pc_q, cause_q;
  logic              illegal_q, rd_wen_q;
  logic [4:0]        resp_rd_idx_q;
  logic [XLEN-1:0]   resp_rd_data_q;

  logic [XLEN-1:0]   src, new_val;
  logic              do_write, illegal, w_enable;

  // Operand decode from the latched instruction; funct3[1:0] selects the op.
  always_comb begin
    src      = funct3_q[2] ? XLEN'(idx_q) : val_q;
    do_write = (funct3_q[1:0] == 2'b01) || (idx_q != 5'd0);
    illegal  = (funct3_q[1:0] == 2'b00) || (do_write && (csr_q[11:10] == 2'b11));
    case (funct3_q[1:0])
      2'b10:   new_val = csr_rdata | src;
      2'b11:   new_val = csr_rdata & ~src;
      default: new_val = src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rd_wen    = 1'b0;
    resp_illegal   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    csr_addr       = '0;
    csr_wdata      = '0;
    w_enable       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = !trap_valid && rst_n;
        if (trap_valid)     state_d = S_TRAP_EPC;
        else if (req_valid) state_d = S_READ;
      end
      S_READ: begin
        csr_addr = csr_q;
        state_d  = (do_write && !illegal) ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        csr_addr  = csr_q;
        csr_wdata = new_q;
        w_enable  = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        resp_rd_wen  = rd_wen_q;
        resp_illegal = illegal_q;
        state_d      = S_IDLE;
      end
      S_TRAP_EPC: begin
        csr_addr  = ADDR_MEPC;
        csr_wdata = pc_q;
        w_enable  = 1'b1;
        state_d   = S_TRAP_CAUSE;
      end
      S_TRAP_CAUSE: begin
        csr_addr  = ADDR_MCAUSE;
        csr_wdata = cause_q;
        w_enable  = 1'b1;
        state_d   = S_TRAP_REDIR;
      end
      S_TRAP_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = mtvec & ~XLEN'(3);
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    csr_w_enable = w_enable && rst_n;
  end

  // Request/trap capture and response holding registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      funct3_q       <= '0;
      csr_q          <= '0;
      idx_q          <= '0;
      val_q          <= '0;
      rd_q           <= '0;
      old_q          <= '0;
      new_q          <= '0;
      pc_q           <= '0;
      cause_q        <= '0;
      illegal_q      <= 1'b0;
      rd_wen_q       <= 1'b0;
      resp_rd_idx_q  <= '0;
      resp_rd_data_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        if (trap_valid) begin
          pc_q    <= trap_pc;
          cause_q <= trap_cause;
        end else if (req_valid) begin
          funct3_q <= req_funct3;
          csr_q    <= req_csr;
          idx_q    <= req_rs1_idx;
          val_q    <= req_rs1_val;
          rd_q     <= req_rd_idx;
        end
      end
      if (state_q == S_READ) begin
        old_q     <= csr_rdata;
        new_q     <= new_val;
        illegal_q <= illegal;
        rd_wen_q  <= !illegal && (rd_q != 5'd0);
      end
      // Response data only changes on entry to RESP so it holds between responses.
      if (state_d == S_RESP && state_q != S_RESP) begin
        resp_rd_idx_q  <= rd_q;
        resp_rd_data_q <= (state_q == S_READ) ? csr_rdata : old_q;
      end
    end
  end

  assign resp_rd_idx  = resp_rd_idx_q;
  assign resp_rd_data = resp_rd_data_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: CSR file model, transaction-level reference model,
// and a scoreboard monitor sampling on the falling edge.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [4:0]  req_rs1_idx, req_rd_idx;
  logic [31:0] req_rs1_val;
  logic        resp_valid, resp_rd_wen, resp_illegal;
  logic [4:0]  resp_rd_idx;
  logic [31:0] resp_rd_data;
  logic        trap_valid;
  logic [31:0] trap_pc, trap_cause;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        csr_w_enable;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, mtvec;

  csr_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr(req_csr), .req_rs1_idx(req_rs1_idx), .req_rs1_val(req_rs1_val),
    .req_rd_idx(req_rd_idx),
    .resp_valid(resp_valid), .resp_rd_wen(resp_rd_wen), .resp_rd_idx(resp_rd_idx),
    .resp_rd_data(resp_rd_data), .resp_illegal(resp_illegal),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_w_enable(csr_w_enable), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .mtvec(mtvec)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic wen; logic [4:0] rd; logic [31:0] data; logic ill; } resp_t;
  typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] pc; } redir_t;

  resp_t  rq[$];
  wr_t    wq[$];
  redir_t dq[$];

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [11:0] addrs   [0:6];

  int   cyc = 0;
  int   busy_until = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic rst_at_edge = 1'b0;
  logic acc_req = 1'b0;
  logic acc_trap = 1'b0;

  assign csr_rdata = mem[csr_addr];

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
    if (csr_w_enable === 1'b1) mem[csr_addr] <= csr_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one instruction is an indivisible read-modify-write of ref_mem.
  task automatic model_req();
    logic [31:0] src, old, nv;
    logic        ill, wr;
    int          lat;
    src = req_funct3[2] ? {27'd0, req_rs1_idx} : req_rs1_val;
    old = ref_mem[req_csr];
    case (req_funct3)
      3'd1, 3'd5: begin nv = src;        wr = 1'b1; end
      3'd2, 3'd6: begin nv = old | src;  wr = (req_rs1_idx != 0); end
      3'd3, 3'd7: begin nv = old & ~src; wr = (req_rs1_idx != 0); end
      default:    begin nv = old;        wr = 1'b0; end
    endcase
    ill = (req_funct3 == 3'd0) || (req_funct3 == 3'd4) || (wr && req_csr >= 12'hC00);
    lat = (wr && !ill) ? 3 : 2;
    if (wr && !ill) wq.push_back('{cyc + 2, req_csr, nv});
    rq.push_back('{cyc + lat, !ill && (req_rd_idx != 0), req_rd_idx, old, ill});
    busy_until = cyc + lat;
  endtask

  // Scoreboard monitor: checks the current cycle, then records new acceptances.
  always @(negedge clk) begin
    logic idle, ew, er, ed;
    acc_req  = 1'b0;
    acc_trap = 1'b0;
    if (!rst_n) begin
      rq.delete(); wq.delete(); dq.delete();
      busy_until = cyc;
    end
    if (!rst_at_edge) begin
      chk("reset_flags", {27'd0, resp_valid, resp_rd_wen, resp_illegal, redirect_valid, csr_w_enable}, 32'd0);
      chk("reset_rd_idx", {27'd0, resp_rd_idx}, 32'd0);
      chk("reset_rd_data", resp_rd_data, 32'd0);
      chk("reset_redirect_pc", redirect_pc, 32'd0);
      chk("reset_csr_bus", {20'd0, csr_addr} | csr_wdata, 32'd0);
    end
    idle = (cyc > busy_until) && rst_n;
    chk("req_ready", {31'd0, req_ready}, {31'd0, idle && !trap_valid});

    ew = (wq.size() > 0) && (wq[0].cyc == cyc);
    chk("csr_w_enable", {31'd0, csr_w_enable}, {31'd0, ew});
    if (ew) begin
      chk("csr_addr", {20'd0, csr_addr}, {20'd0, wq[0].addr});
      chk("csr_wdata", csr_wdata, wq[0].data);
      ref_mem[wq[0].addr] = wq[0].data;
      void'(wq.pop_front());
    end

    er = (rq.size() > 0) && (rq[0].cyc == cyc);
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, er});
    if (er) begin
      chk("resp_rd_wen", {31'd0, resp_rd_wen}, {31'd0, rq[0].wen});
      chk("resp_illegal", {31'd0, resp_illegal}, {31'd0, rq[0].ill});
      chk("resp_rd_idx", {27'd0, resp_rd_idx}, {27'd0, rq[0].rd});
      chk("resp_rd_data", resp_rd_data, rq[0].data);
      void'(rq.pop_front());
    end

    ed = (dq.size() > 0) && (dq[0].cyc == cyc);
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, ed});
    if (ed) begin
      chk("redirect_pc", redirect_pc, dq[0].pc);
      void'(dq.pop_front());
    end

    if (idle && trap_valid) begin
      acc_trap = 1'b1;
      wq.push_back('{cyc + 1, 12'h341, trap_pc});
      wq.push_back('{cyc + 2, 12'h342, trap_cause});
      dq.push_back('{cyc + 3, {mtvec[31:2], 2'b00}});
      busy_until = cyc + 3;
    end else if (idle && req_valid) begin
      acc_req = 1'b1;
      model_req();
    end
  end

  task automatic do_req(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] idx,
                        input logic [31:0] val, input logic [4:0] rd);
    int n;
    req_valid = 1'b1; req_funct3 = f3; req_csr = csr;
    req_rs1_idx = idx; req_rs1_val = val; req_rd_idx = rd;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!acc_req && n < 100);
    if (!acc_req) chk("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause);
    int n;
    trap_valid = 1'b1; trap_pc = pc; trap_cause = cause;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!acc_trap && n < 100);
    if (!acc_trap) chk("trap_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    trap_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    addrs[0] = 12'h340; addrs[1] = 12'h300; addrs[2] = 12'h341; addrs[3] = 12'h342;
    addrs[4] = 12'hC00; addrs[5] = 12'hC01; addrs[6] = 12'h305;
    for (int i = 0; i < 4096; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    for (int i = 0; i < 7; i++) begin
      mem[addrs[i]] = $urandom; ref_mem[addrs[i]] = mem[addrs[i]];
    end
    mem[12'h340] = 32'h11; ref_mem[12'h340] = 32'h11;
    rst_n = 1'b0; req_valid = 1'b0; trap_valid = 1'b0;
    req_funct3 = '0; req_csr = '0; req_rs1_idx = '0; req_rs1_val = '0; req_rd_idx = '0;
    trap_pc = '0; trap_cause = '0; mtvec = 32'h8000_0001;
    settle(3);
    rst_n = 1'b1;
    settle(2);

    // CSRRW then read back with CSRRS x0 (no write, short latency)
    do_req(3'b001, 12'h340, 5'd7, 32'hDEAD_BEEF, 5'd5);
    settle(4);
    chk("mscratch_after_rw", mem[12'h340], 32'hDEAD_BEEF);
    do_req(3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd3);
    settle(3);
    // CSRRWI 0xF then CSRRCI 0x3 leaves 0xC
    do_req(3'b101, 12'h300, 5'h0F, 32'h0, 5'd1);
    do_req(3'b111, 12'h300, 5'h03, 32'hFFFF_FFFF, 5'd2);
    settle(4);
    chk("rci_result", mem[12'h300], 32'h0000_000C);
    // Illegal forms, and the legal read of a read-only CSR
    do_req(3'b001, 12'hC00, 5'd4, 32'h1234_5678, 5'd6);
    do_req(3'b100, 12'h340, 5'd4, 32'h1, 5'd6);
    do_req(3'b010, 12'hC00, 5'd0, 32'h1, 5'd6);
    settle(3);
    // Trap entry
    do_trap(32'h8000_0104, 32'h2);
    settle(4);
    chk("mepc", mem[12'h341], 32'h8000_0104);
    chk("mcause", mem[12'h342], 32'h2);
    // Trap and request together: trap first, request stays pending
    req_valid = 1'b1; req_funct3 = 3'b110; req_csr = 12'h300;
    req_rs1_idx = 5'h10; req_rs1_val = 32'h0; req_rd_idx = 5'd9;
    do_trap(32'h0000_2000, 32'h8000_000B);
    do_req(3'b110, 12'h300, 5'h10, 32'h0, 5'd9);
    settle(4);

    // Randomized mix, mostly back-to-back
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 7) == 0)
        do_trap($urandom, $urandom);
      else
        do_req(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 6)],
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
               $urandom, 5'($urandom));
      if ($urandom_range(0, 3) == 0) settle($urandom_range(1, 4));
    end
    settle(5);

    // Reset asserted during the WRITE cycle of an RMW
    do_req(3'b001, 12'h300, 5'd9, 32'hA5A5_5A5A, 5'd4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    settle(2);
    rst_n = 1'b1;
    settle(3);

    n = 0;
    while ((rq.size() + wq.size() + dq.size()) != 0 && n < 20) begin settle(1); n++; end
    chk("drain_pending", 32'(rq.size() + wq.size() + dq.size()), 32'd0);
    for (int i = 0; i < 7; i++) chk("csr_file_vs_model", mem[addrs[i]], ref_mem[addrs[i]]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Initiator side of the CSR register-file port. It accepts decoded Zicsr instructions from the execute stage and runs the read-modify-write sequence against the CSR file. It also runs the machine-trap entry sequence (write mepc, write mcause, redirect to mtvec). It sits between the execute stage and the CSR file, and is the only driver of the file's write-enable, address and write-data inputs.

## Interface
- XLEN, 32, data width of CSR values and PC.
- ADDR_W, 12, CSR address width.
- ADDR_MEPC, 12'h341, mepc address.
- ADDR_MCAUSE, 12'h342, mcause address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  CSR instruction present.
- req_ready  out  1  unit can accept a request.
- req_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- req_csr  in  12  CSR address.
- req_rs1_idx  in  5  rs1 index; zimm for the immediate forms.
- req_rs1_val  in  32  rs1 value; ignored for the immediate forms.
- req_rd_idx  in  5  destination register.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rd_wen  out  1  write resp_rd_data to rd.
- resp_rd_idx  out  5  latched rd.
- resp_rd_data  out  32  old CSR value.
- resp_illegal  out  1  illegal-instruction flag.
- trap_valid  in  1  trap-entry request.
- trap_pc  in  32  faulting PC.
- trap_cause  in  32  mcause value.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  32  trap target.
- csr_w_enable  out  1  CSR file write strobe.
- csr_addr  out  12  CSR file address.
- csr_wdata  out  32  CSR file write data.
- csr_rdata  in  32  combinational read data for csr_addr.
- mtvec  in  32  live mtvec from the CSR file.

## Operation
- States are IDLE, READ, WRITE, RESP, TRAP_EPC, TRAP_CAUSE and TRAP_REDIR.
- req_ready = (state==IDLE) && !trap_valid && rst_n.

Transitions:
- IDLE: trap_valid latches trap_pc and trap_cause, then goes to TRAP_EPC. If trap_valid is low, req_valid latches all req_* fields, then goes to READ. trap_valid has priority over req_valid.
- READ: csr_addr=latched CSR and csr_w_enable=0. Captures csr_rdata as old and computes new. Goes to WRITE when do_write && legal, otherwise to RESP.
- WRITE: csr_addr=latched CSR, csr_wdata=new, csr_w_enable=1. Goes to RESP.
- RESP: resp_valid=1, then IDLE.
- TRAP_EPC: writes trap_pc to ADDR_MEPC, then TRAP_CAUSE.
- TRAP_CAUSE: writes trap_cause to ADDR_MCAUSE, then TRAP_REDIR.
- TRAP_REDIR: redirect_valid=1, redirect_pc={mtvec[31:2],2'b00}, then IDLE.

Data rules:
- src = rs1_val for RW/RS/RC; src = zero-extended 5-bit zimm for RWI/RSI/RCI.
- new = src for RW/RWI; old|src for RS/RSI; old&~src for RC/RCI.
- do_write = 1 for RW/RWI. For the other four forms, do_write = (rs1_idx!=0).
- illegal = funct3 is 000 or 100, or (do_write && csr[11:10]==2'b11) (read-only CSR).
- resp_rd_wen = !illegal && rd_idx!=0. resp_illegal = illegal. An illegal request writes nothing.
- resp_rd_data = old. It is held from RESP until the next RESP.

Reset:
- rst_n low on a posedge forces state to IDLE. Any in-flight RMW or trap sequence is abandoned with no further writes.
- csr_w_enable is gated combinationally with rst_n, so no write occurs while rst_n is low.
- Reset values: req_ready 0 (1 once rst_n is high). resp_valid, resp_rd_wen, resp_illegal, redirect_valid, csr_w_enable are 0. resp_rd_idx, resp_rd_data, redirect_pc, csr_addr, csr_wdata are 0.

## Timing
- Accept edge T: READ in T+1, WRITE in T+2, resp_valid in T+3.
- With no write (suppressed or illegal), resp_valid is in T+2.
- Trap accepted at T: mepc written at the end of T+1, mcause at the end of T+2, redirect_valid in T+3.
- redirect_pc reflects mtvec as sampled in T+3.
- Requests presented while the unit is busy wait; req_ready stays low until the cycle after RESP or TRAP_REDIR.
- resp_valid and redirect_valid are each high for exactly one cycle. There is no backpressure.
- A trap and a request presented in the same IDLE cycle: the trap is taken and the request stays pending.

## Test plan
- CSRRW csr=0x340, rs1_val=0xDEADBEEF, rd=5, file holds 0x11: resp at T+3 with rd_data 0x11 and rd_wen 1; mscratch reads 0xDEADBEEF afterwards.
- CSRRS csr=0x340, rs1_idx=0, rd=3: no csr_w_enable pulse; resp at T+2 with old value and rd_wen 1. CSRRCI zimm=0x3 on 0xF gives 0xC.
- CSRRW csr=0xC00 (read-only): no write; resp_illegal 1, rd_wen 0. funct3=100 is also illegal. CSRRS x0 on 0xC00 is legal.
- trap_valid with pc=0x80000104, cause=0x2, mtvec=0x80000001: mepc=0x80000104, mcause=0x2, redirect_pc=0x80000000 at T+3.
- trap_valid and req_valid asserted together: trap sequence first, then the request; back-to-back requests give req_ready low for the busy cycles.
- rst_n low during the WRITE cycle: no write reaches the file, all outputs take their reset values, and req_ready is 1 after release.
